// File: rtl/dcache_pkg.sv
// Shared types, widths and address-field helpers for the write-back data cache.
package dcache_pkg;

  localparam int ADDR_W   = 30;
  localparam int WORD_W   = 32;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLOCK_W  = 128;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } dc_state_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage for the direct-mapped cache: one combinational
// read of a whole entry, synchronous word or block writes.
module dcache_array #(
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = 25,
  parameter int BLOCK_W  = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  index,
  input  logic                word_we,
  input  logic [OFFSET_W-1:0] word_off,
  input  logic [31:0]         word_data,
  input  logic                block_we,
  input  logic [TAG_W-1:0]    block_tag,
  input  logic [BLOCK_W-1:0]  block_data,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [BLOCK_W-1:0]  rd_data
);
  import dcache_pkg::*;

  localparam int DEPTH = 1 << INDEX_W;

  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_mem  [DEPTH];
  logic [BLOCK_W-1:0] data_mem [DEPTH];

  // Status bits: cleared on reset, set/cleared by fills and stores.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (block_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data payload; a block fill takes priority over a word store.
  // NOTE: the payload arrays have no reset -- valid gates every use, and
  // leaving them unreset lets synthesis map them to plain RAM.
  always_ff @(posedge clk) begin
    if (block_we) begin
      tag_mem[index]  <= block_tag;
      data_mem[index] <= block_data;
    end else if (word_we) begin
      data_mem[index][int'(word_off)*WORD_W +: WORD_W] <= word_data;
    end
  end

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_mem[index];
  assign rd_data  = data_mem[index];

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate cache: zero-stall hits, and a
// WRITEBACK/ALLOCATE sequence on the 128-bit block bus for misses.
module dcache_wb #(
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                proc_ren,
  input  logic                proc_wen,
  input  logic [29:0]         proc_addr,
  input  logic [31:0]         proc_wdata,
  output logic                proc_stall,
  output logic [31:0]         proc_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [29-OFFSET_W:0] mem_addr,
  output logic [127:0]        mem_wdata,
  input  logic                mem_ready,
  input  logic [127:0]        mem_rdata
);
  import dcache_pkg::*;

  dc_state_t state_q, state_d;

  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic [OFFSET_W-1:0] offset;
  logic                req;
  logic                hit;
  logic                word_we;
  logic                block_we;
  logic                rd_valid;
  logic                rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [BLOCK_W-1:0]  rd_data;

  assign index  = get_index(proc_addr);
  assign tag    = get_tag(proc_addr);
  assign offset = get_offset(proc_addr);
  assign req    = proc_ren | proc_wen;
  assign hit    = rd_valid && (rd_tag == tag);

  dcache_array #(
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W),
    .TAG_W    (TAG_W),
    .BLOCK_W  (BLOCK_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .index      (index),
    .word_we    (word_we),
    .word_off   (offset),
    .word_data  (proc_wdata),
    .block_we   (block_we),
    .block_tag  (tag),
    .block_data (mem_rdata),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data)
  );

  // State register; reset aborts any in-flight memory request.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, stall, memory-bus drive and array write enables.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = proc_addr[29:OFFSET_W];
    word_we    = 1'b0;
    block_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // A simultaneous read and write resolves as a write.
            word_we = proc_wen;
          end else begin
            proc_stall = 1'b1;
            state_d    = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {rd_tag, index};
        if (mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        if (mem_ready) begin
          block_we = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_wdata  = rd_data;
  assign proc_rdata = rd_data[int'(offset)*WORD_W +: WORD_W];

endmodule

// File: doc/dcache_wb.md
# dcache_wb

Direct-mapped, write-back, write-allocate data cache that is the responder on the pipeline's `DCACHE_*` port (ren/wen/addr/wdata/stall/rdata) and the initiator on a 128-bit block memory bus. Hits complete with zero stall cycles. Misses hold `proc_stall` high while a dirty victim is written back and the missing block is fetched. The same block can serve the `ICACHE_*` port, where `proc_wen` is tied low.

## Interface
Parameters:
- `INDEX_W`, 3: index bits; the cache has 2^INDEX_W blocks.
- `OFFSET_W`, 2: word-offset bits; 4 words (128 bits) per block.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `proc_ren` input 1: processor read request.
- `proc_wen` input 1: processor write request.
- `proc_addr` input 30: word address. Fields: [1:0] offset, [4:2] index, [29:5] tag.
- `proc_wdata` input 32: store data.
- `proc_stall` output 1: request not yet serviced; the processor holds all inputs stable while it is high.
- `proc_rdata` output 32: load data, valid when `proc_ren` is high and `proc_stall` is low.
- `mem_read` output 1: block read request.
- `mem_write` output 1: block write request.
- `mem_addr` output 28: block address, `{tag,index}`.
- `mem_wdata` output 128: victim block; word 0 occupies [31:0].
- `mem_ready` input 1: one-cycle pulse that completes the current memory request.
- `mem_rdata` input 128: fill data, valid in the `mem_ready` cycle.

## Operation
- Per-block state: valid bit, dirty bit, 25-bit tag, 128-bit data.
- Hit = valid and stored tag equal to `proc_addr[29:5]`.
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: `proc_stall` = 0, no memory activity.
- IDLE, read hit: `proc_rdata` is the selected word (combinational); `proc_stall` = 0.
- IDLE, write hit: the word is written at the clock edge and dirty is set; `proc_stall` = 0.
- IDLE, miss: `proc_stall` = 1 combinationally. Next state is WRITEBACK if the victim is valid and dirty, otherwise ALLOCATE.
- WRITEBACK:
  - `mem_write` = 1, `mem_addr` = `{victim tag, index}`, `mem_wdata` = victim data.
  - On `mem_ready`, go to ALLOCATE.
- ALLOCATE:
  - `mem_read` = 1, `mem_addr` = `proc_addr[29:2]`.
  - On `mem_ready`, write `mem_rdata` into the block, set valid, clear dirty, store the tag, and go to IDLE.
  - The access then completes as a hit in IDLE.
- `mem_read` and `mem_write` are decoded from the state, never asserted together, and held until `mem_ready`.
- `proc_stall` = 1 in every cycle spent in WRITEBACK or ALLOCATE.
- `proc_ren` and `proc_wen` both high is illegal. The cache treats it as a write.
- `mem_ready` outside WRITEBACK or ALLOCATE is ignored.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - All valid and dirty bits cleared; state = IDLE.
  - `mem_read` = `mem_write` = 0 and `proc_stall` = 0 in the following cycle when there is no request.
  - Data and tag arrays are not reset.
- Reset asserted during WRITEBACK or ALLOCATE:
  - The memory request is dropped immediately.
  - The memory model restarts with the cache; partial transfers leave no state.
- Hit latency: 0 stall cycles. Load data is available in the same cycle.
- Clean miss detected in cycle N, with `mem_ready` in cycle N+k:
  - `proc_stall` is high for cycles N to N+k.
  - The hit completes in cycle N+k+1 with `proc_stall` = 0.
- Dirty miss adds the writeback's memory latency plus one cycle for the ALLOCATE transition.
- A new `proc_addr` may be presented in the cycle after `proc_stall` falls.

## Structure
- Package `dcache_pkg` holds:
  - `TAG_W`, `INDEX_W`, `OFFSET_W`, `BLOCK_W` = 128.
  - The state enum `dc_state_t` (IDLE, WRITEBACK, ALLOCATE).
  - Field-extraction helper functions for `proc_addr`.
- Sub-module `dcache_array` holds the valid, dirty, tag and data storage:
  - synchronous write ports for a single word or a full block;
  - combinational read of a full entry;
  - synchronous clear of valid and dirty on reset.
- The top level contains the FSM, the hit compare and the memory-bus muxing.

## Test plan
- After reset, read 0x00000010 with memory returning `mem_rdata` = {32'hD,32'hC,32'hB,32'hA} three cycles after `mem_read`:
  - `mem_addr` = 0x0000004 and `mem_read` high until `mem_ready`;
  - then `proc_rdata` = 32'hA with `proc_stall` low.
- After the fill, read 0x00000013: `proc_rdata` = 32'hD with zero stall cycles and no memory activity.
- Write 32'h1234 to 0x00000011, then read it back: zero stalls and read data = 32'h1234.
- Then read 0x00000031 (same index, different tag):
  - first `mem_write` with `mem_addr` = 0x0000004 and `mem_wdata` = {32'hD,32'hC,32'h1234,32'hA};
  - then `mem_read` with `mem_addr` = 0x000000C;
  - `proc_stall` stays high throughout.
- Assert `rst_n` = 0 during an ALLOCATE wait:
  - `mem_read` drops at the next edge;
  - a re-read of the same address misses again.
- Hold `mem_ready` high while idle with no request: no state change and `proc_stall` = 0.
